// File: rtl/sdf_r2_stage_8_if.sv
// Sample/twiddle stream into and rotated sample stream out of one radix-2 SDF stage.
interface sdf_r2_stage_8_if #(
  parameter int DATA_W = 24
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic [1:0]               state;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;
  logic [3:0]               out_idx;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i, out_idx
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i, out_idx
  );
endinterface

// File: rtl/sdf_r2_stage_8.sv
// Radix-2 SDF butterfly stage: DELAY-deep complex feedback line, butterfly,
// twiddle rotation and a registered output stream with a running 4-bit index.
module sdf_r2_stage_8 #(
  parameter int DATA_W = 24,
  parameter int DELAY  = 8
) (
  input  logic            clk,
  input  logic            rst,
  sdf_r2_stage_8_if.slave bus
);
  typedef enum logic [1:0] {
    PH_FILL = 2'd0,
    PH_BFLY = 2'd1,
    PH_ROT  = 2'd2,
    PH_ILL  = 2'd3
  } phase_t;

  localparam int PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] dl_r [DELAY];
  logic signed [DATA_W-1:0] dl_i [DELAY];

  phase_t                   phase;
  logic                     adv;
  logic                     emit;
  logic signed [DATA_W-1:0] x_r, x_i;
  logic signed [DATA_W-1:0] head_r, head_i;
  logic signed [DATA_W-1:0] push_r, push_i;
  logic signed [DATA_W-1:0] c_r, c_i;
  logic signed [PW-1:0]     cr_x, ci_x, wr_x, wi_x;
  logic signed [PW-1:0]     re_full, im_full;
  logic signed [DATA_W-1:0] rot_r, rot_i;
  logic [2*DATA_W-1:0]      rot_unused;

  assign phase = phase_t'(bus.state);

  always_comb begin
    adv    = bus.in_valid | (bus.state != 2'd0);
    x_r    = bus.in_valid ? bus.din_r : '0;
    x_i    = bus.in_valid ? bus.din_i : '0;
    head_r = dl_r[DELAY-1];
    head_i = dl_i[DELAY-1];
    push_r = x_r;
    push_i = x_i;
    c_r    = '0;
    c_i    = '0;
    emit   = 1'b0;
    case (phase)
      PH_BFLY: begin
        push_r = head_r - x_r;
        push_i = head_i - x_i;
        c_r    = head_r + x_r;
        c_i    = head_i + x_i;
        emit   = 1'b1;
      end
      PH_ROT: begin
        c_r  = head_r;
        c_i  = head_i;
        emit = 1'b1;
      end
      default: begin
        push_r = x_r;
        push_i = x_i;
      end
    endcase
  end

  // Full-precision complex multiply; the kept slice is an arithmetic >> 8 wrapped to DATA_W.
  always_comb begin
    cr_x    = {{DATA_W{c_r[DATA_W-1]}}, c_r};
    ci_x    = {{DATA_W{c_i[DATA_W-1]}}, c_i};
    wr_x    = {{DATA_W{bus.w_r[DATA_W-1]}}, bus.w_r};
    wi_x    = {{DATA_W{bus.w_i[DATA_W-1]}}, bus.w_i};
    re_full = cr_x * wr_x - ci_x * wi_x;
    im_full = cr_x * wi_x + ci_x * wr_x;
    rot_r   = re_full[DATA_W+7:8];
    rot_i   = im_full[DATA_W+7:8];
  end

  assign rot_unused = {re_full[PW-1:DATA_W+8], re_full[7:0],
                       im_full[PW-1:DATA_W+8], im_full[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
      bus.dout_r    <= '0;
      bus.dout_i    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
    end else begin
      if (bus.out_valid) begin
        bus.out_idx <= bus.out_idx + 4'd1;
      end
      if (adv) begin
        for (int unsigned i = 1; i < DELAY; i++) begin
          dl_r[i] <= dl_r[i-1];
          dl_i[i] <= dl_i[i-1];
        end
        dl_r[0] <= push_r;
        dl_i[0] <= push_i;
        if (emit) begin
          bus.dout_r <= rot_r;
          bus.dout_i <= rot_i;
        end
        bus.out_valid <= emit;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdf_r2_stage_8.sv
// Randomized bench for sdf_r2_stage_8 against a queue-based frame model.
module tb_sdf_r2_stage_8;
  typedef logic signed [23:0] s24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdf_r2_stage_8_if #(.DATA_W(24)) bus();

  sdf_r2_stage_8 #(.DATA_W(24), .DELAY(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int tw_r [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int tw_i [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  s24       mq_r [$];
  s24       mq_i [$];
  bit       ev;
  s24       er, ei;
  logic [3:0] eidx;

  int got_r [$];
  int got_i [$];
  int got_idx [$];

  int fr_r [4][16];
  int fr_i [4][16];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd24();
    return int'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  task automatic model_reset();
    mq_r.delete();
    mq_i.delete();
    for (int k = 0; k < 8; k++) begin
      mq_r.push_back('0);
      mq_i.push_back('0);
    end
    ev   = 1'b0;
    er   = '0;
    ei   = '0;
    eidx = '0;
  endtask

  // Delay line as a FIFO of the last eight pushes; front is the oldest.
  task automatic model_step(input bit v, input int dr, input int di, input int st,
                            input int wr, input int wi, input bit r);
    s24 xr, xi, hr, hi, cr, ci, pr, pi;
    bit emit;
    longint re, im;
    if (r) begin
      model_reset();
      return;
    end
    if (ev) eidx = eidx + 4'd1;
    if (!(v || st != 0)) begin
      ev = 1'b0;
      return;
    end
    xr = v ? s24'(dr) : s24'(0);
    xi = v ? s24'(di) : s24'(0);
    hr = mq_r[0];
    hi = mq_i[0];
    cr = '0; ci = '0; pr = xr; pi = xi; emit = 1'b0;
    if (st == 1) begin
      cr = hr + xr; ci = hi + xi;
      pr = hr - xr; pi = hi - xi;
      emit = 1'b1;
    end else if (st == 2) begin
      cr = hr; ci = hi;
      emit = 1'b1;
    end
    void'(mq_r.pop_front());
    void'(mq_i.pop_front());
    mq_r.push_back(pr);
    mq_i.push_back(pi);
    if (emit) begin
      re = longint'(cr) * longint'(wr) - longint'(ci) * longint'(wi);
      im = longint'(cr) * longint'(wi) + longint'(ci) * longint'(wr);
      er = s24'(re >>> 8);
      ei = s24'(im >>> 8);
    end
    ev = emit;
  endtask

  task automatic cycle(input bit v, input int dr, input int di, input int st,
                       input int wr, input int wi, input bit r);
    rst          = r;
    bus.in_valid = v;
    bus.din_r    = s24'(dr);
    bus.din_i    = s24'(di);
    bus.state    = 2'(st);
    bus.w_r      = s24'(wr);
    bus.w_i      = s24'(wi);
    @(posedge clk);
    model_step(v, s24'(dr), s24'(di), st, s24'(wr), s24'(wi), r);
    #1;
    check("out_valid", longint'(bus.out_valid), longint'(ev));
    check("dout_r", longint'(bus.dout_r), longint'(er));
    check("dout_i", longint'(bus.dout_i), longint'(ei));
    check("out_idx", longint'(bus.out_idx), longint'(eidx));
    if (bus.out_valid) begin
      got_r.push_back(int'(bus.dout_r));
      got_i.push_back(int'(bus.dout_i));
      got_idx.push_back(int'(bus.out_idx));
    end
    @(negedge clk);
  endtask

  task automatic maybe_stall(input bit stalls);
    if (stalls && $urandom_range(0, 3) == 0)
      cycle(1'b0, rnd24(), rnd24(), 0, rnd24(), rnd24(), 1'b0);
  endtask

  task automatic run_frames(input int n, input bit stalls);
    got_r.delete(); got_i.delete(); got_idx.delete();
    for (int k = 0; k < 8; k++) begin
      maybe_stall(stalls);
      cycle(1'b1, fr_r[0][k], fr_i[0][k], 0, rnd24(), rnd24(), 1'b0);
    end
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 8; k++) begin
        maybe_stall(stalls);
        cycle(1'b1, fr_r[f][k+8], fr_i[f][k+8], 1, 256, 0, 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
        maybe_stall(stalls);
        if (f + 1 < n)
          cycle(1'b1, fr_r[f+1][k], fr_i[f+1][k], 2, tw_r[k], tw_i[k], 1'b0);
        else
          cycle(1'b0, rnd24(), rnd24(), 2, tw_r[k], tw_i[k], 1'b0);
      end
    end
    cycle(1'b0, rnd24(), rnd24(), 0, rnd24(), rnd24(), 1'b0);
  endtask

  task automatic set_const();
    for (int n = 0; n < 16; n++) begin
      fr_r[0][n] = 100;
      fr_i[0][n] = 0;
    end
  endtask

  task automatic check_const(input string tag);
    check({tag, "_count"}, got_r.size(), 16);
    for (int k = 0; k < 16 && k < got_r.size(); k++) begin
      check({tag, "_re"}, got_r[k], (k < 8) ? 200 : 0);
      check({tag, "_im"}, got_i[k], 0);
      check({tag, "_idx"}, got_idx[k], k);
    end
  endtask

  initial begin
    model_reset();
    bus.in_valid = 1'b0;
    bus.din_r = '0; bus.din_i = '0; bus.state = '0;
    bus.w_r = '0; bus.w_i = '0;
    @(negedge clk);

    for (int c = 0; c < 2; c++)
      cycle(1'($urandom_range(0, 1)), rnd24(), rnd24(), int'($urandom_range(0, 3)),
            rnd24(), rnd24(), 1'b1);
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_dout_r", longint'(bus.dout_r), 0);
    check("rst_idx", longint'(bus.out_idx), 0);

    set_const();
    run_frames(1, 1'b0);
    check_const("const");

    for (int n = 0; n < 16; n++) begin
      fr_r[0][n] = (n < 8) ? 100 : -100;
      fr_i[0][n] = 0;
    end
    run_frames(1, 1'b0);
    if (got_r.size() == 16) begin
      check("step_sum0", got_r[0], 0);
      check("step_out8_re", got_r[8], 200);
      check("step_out8_im", got_i[8], 0);
      check("step_out10_re", got_r[10], 141);
      check("step_out10_im", got_i[10], -142);
      check("step_out12_re", got_r[12], 0);
      check("step_out12_im", got_i[12], -200);
    end else begin
      check("step_count", got_r.size(), 16);
    end

    for (int n = 0; n < 16; n++) begin
      fr_r[0][n] = 0;
      fr_i[0][n] = 0;
    end
    fr_r[0][0] = 24'h7FFFFF;
    fr_r[0][8] = 1;
    run_frames(1, 1'b0);
    if (got_r.size() == 16) begin
      check("wrap_sum_re", got_r[0], -8388608);
      check("wrap_diff_re", got_r[8], 8388606);
    end else begin
      check("wrap_count", got_r.size(), 16);
    end

    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 16; n++) begin
        fr_r[f][n] = rnd24();
        fr_i[f][n] = rnd24();
      end
    run_frames(3, 1'b1);
    check("b2b_count", got_r.size(), 48);

    for (int k = 0; k < 8; k++)
      cycle(1'b1, rnd24(), rnd24(), 0, rnd24(), rnd24(), 1'b0);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, rnd24(), rnd24(), 1, 256, 0, 1'b0);
    cycle(1'b1, rnd24(), rnd24(), 1, 256, 0, 1'b1);
    set_const();
    run_frames(1, 1'b0);
    check_const("midrst");

    for (int c = 0; c < 300; c++)
      cycle(1'($urandom_range(0, 1)), rnd24(), rnd24(), int'($urandom_range(0, 3)),
            rnd24(), rnd24(), ($urandom_range(0, 39) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
